// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage MIPS core: Tuse/Tnew data-hazard stalls,
// mult/div sequencing with its busy countdown, and the pipeline register controls.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_IR,
    input  logic [31:0] E_IR,
    input  logic [4:0]  E_WA,
    input  logic [31:0] M_IR,
    input  logic [4:0]  M_WA,
    output logic        stall,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_clear,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic [4:0] {
        OP_NONE,
        OP_ADDU,
        OP_SUBU,
        OP_JR,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO,
        OP_ORI,
        OP_LUI,
        OP_LW,
        OP_SW,
        OP_BEQ,
        OP_JAL
    } op_t;

    // Tuse value 3 means "operand not read"; it can never be below any Tnew (max 2).
    localparam logic [1:0] NO_USE = 2'd3;

    localparam int NUM_STAGES = 3;
    localparam int NUM_SRCS   = 2;

    function automatic op_t decode_op(input logic [5:0] opc, input logic [5:0] fn);
        op_t op;
        op = OP_NONE;
        case (opc)
            6'b000000: begin
                case (fn)
                    6'b100001: op = OP_ADDU;
                    6'b100011: op = OP_SUBU;
                    6'b001000: op = OP_JR;
                    6'b011000: op = OP_MULT;
                    6'b011001: op = OP_MULTU;
                    6'b011010: op = OP_DIV;
                    6'b011011: op = OP_DIVU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    6'b010001: op = OP_MTHI;
                    6'b010011: op = OP_MTLO;
                    default:   op = OP_NONE;
                endcase
            end
            6'b001101: op = OP_ORI;
            6'b001111: op = OP_LUI;
            6'b100011: op = OP_LW;
            6'b101011: op = OP_SW;
            6'b000100: op = OP_BEQ;
            6'b000011: op = OP_JAL;
            default:   op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_md_arith(input op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_md_any(input op_t op);
        return is_md_arith(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic [1:0] tuse_rs_of(input op_t op);
        logic [1:0] t;
        case (op)
            OP_BEQ, OP_JR:                        t = 2'd0;
            OP_ADDU, OP_SUBU, OP_ORI, OP_LW,
            OP_SW, OP_MULT, OP_MULTU, OP_DIV,
            OP_DIVU, OP_MTHI, OP_MTLO:            t = 2'd1;
            default:                              t = NO_USE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tuse_rt_of(input op_t op);
        logic [1:0] t;
        case (op)
            OP_BEQ:                               t = 2'd0;
            OP_ADDU, OP_SUBU, OP_MULT, OP_MULTU,
            OP_DIV, OP_DIVU:                      t = 2'd1;
            OP_SW:                                t = 2'd2;
            default:                              t = NO_USE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tnew_e_of(input op_t op);
        logic [1:0] t;
        case (op)
            OP_LW:                                t = 2'd2;
            OP_ADDU, OP_SUBU, OP_ORI, OP_LUI,
            OP_MFHI, OP_MFLO:                     t = 2'd1;
            default:                              t = 2'd0;
        endcase
        return t;
    endfunction

    // Per-stage decode: index 0 = D, 1 = E, 2 = M.
    logic [5:0] stage_opc [NUM_STAGES];
    logic [5:0] stage_fn  [NUM_STAGES];
    op_t        stage_op  [NUM_STAGES];

    assign stage_opc[0] = D_IR[31:26];
    assign stage_opc[1] = E_IR[31:26];
    assign stage_opc[2] = M_IR[31:26];
    assign stage_fn[0]  = D_IR[5:0];
    assign stage_fn[1]  = E_IR[5:0];
    assign stage_fn[2]  = M_IR[5:0];

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_decode
            assign stage_op[gi] = decode_op(stage_opc[gi], stage_fn[gi]);
        end
    endgenerate

    op_t        d_op;
    op_t        e_op;
    op_t        m_op;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;

    assign d_op   = stage_op[0];
    assign e_op   = stage_op[1];
    assign m_op   = stage_op[2];
    assign tnew_e = tnew_e_of(e_op);
    assign tnew_m = (m_op == OP_LW) ? 2'd1 : 2'd0;

    // Source operands of D: index 0 = rs, 1 = rt.
    logic [4:0] src_reg   [NUM_SRCS];
    logic [1:0] src_tuse  [NUM_SRCS];
    logic       src_stall [NUM_SRCS];

    assign src_reg[0]  = D_IR[25:21];
    assign src_reg[1]  = D_IR[20:16];
    assign src_tuse[0] = tuse_rs_of(d_op);
    assign src_tuse[1] = tuse_rt_of(d_op);

    generate
        for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src
            logic hit_e;
            logic hit_m;
            assign hit_e = (src_reg[gi] == E_WA) && (src_tuse[gi] < tnew_e);
            assign hit_m = (src_reg[gi] == M_WA) && (src_tuse[gi] < tnew_m);
            assign src_stall[gi] = (src_tuse[gi] != NO_USE) && (src_reg[gi] != 5'd0) &&
                                   (hit_e || hit_m);
        end
    endgenerate

    // Bits of the instruction words that hazard detection never looks at.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{D_IR[15:6], E_IR[25:6], M_IR[25:6]};

    logic [CNT_W-1:0] md_cnt_reg;
    logic [31:0]      stall_cnt_reg;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;

    assign md_busy  = (md_cnt_reg != '0);
    assign md_start = is_md_arith(e_op) && (md_cnt_reg == '0);

    assign stall_rs = src_stall[0];
    assign stall_rt = src_stall[1];
    assign stall_md = is_md_any(d_op) && (md_start || md_busy);
    assign stall    = stall_rs || stall_rt || stall_md;

    assign pc_en       = ~stall;
    assign if_id_en    = ~stall;
    assign id_ex_clear = stall;
    assign stall_cnt   = stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_reg <= '0;
        end else if (md_start) begin
            md_cnt_reg <= ((e_op == OP_DIV) || (e_op == OP_DIVU)) ?
                          CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_reg != '0) begin
            md_cnt_reg <= md_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: data hazards, zero register,
// mult/div sequencing, reset mid-countdown and stall counter saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_IR, E_IR, M_IR;
    logic [4:0]  E_WA, M_WA;
    logic        stall, pc_en, if_id_en, id_ex_clear, md_start, md_busy;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [31:0] NOP   = 32'd0;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_IR        (D_IR),
        .E_IR        (E_IR),
        .E_WA        (E_WA),
        .M_IR        (M_IR),
        .M_WA        (M_WA),
        .stall       (stall),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_clear (id_ex_clear),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one vector and let combinational outputs settle.
    task automatic apply(input string name, input logic [31:0] d, input logic [31:0] e,
                         input logic [4:0] ewa, input logic [31:0] m, input logic [4:0] mwa);
        D_IR = d; E_IR = e; E_WA = ewa; M_IR = m; M_WA = mwa;
        #1;
        $display("[%0t] %s D=%h E=%h/%0d M=%h/%0d -> stall=%0d start=%0d busy=%0d cnt=%0d",
                 $time, name, d, e, ewa, m, mwa, stall, md_start, md_busy, stall_cnt);
    endtask

    initial begin
        reset = 1'b1;
        D_IR = NOP; E_IR = NOP; M_IR = NOP; E_WA = 5'd0; M_WA = 5'd0;
        tick(); tick();
        reset = 1'b0;

        apply("reset", NOP, NOP, 5'd0, NOP, 5'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd1);
        check("rst_if_id_en", {31'd0, if_id_en}, 32'd1);
        check("rst_clear", {31'd0, id_ex_clear}, 32'd0);
        check("rst_start", {31'd0, md_start}, 32'd0);
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        tick();

        // Load-use against E, then resolved once lw reaches M.
        apply("load_use", r_ins(5'd8, 5'd8, 5'd9, F_ADDU), i_ins(O_LW, 5'd0, 5'd8), 5'd8, NOP, 5'd0);
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_pc_en", {31'd0, pc_en}, 32'd0);
        check("lu_if_id_en", {31'd0, if_id_en}, 32'd0);
        check("lu_clear", {31'd0, id_ex_clear}, 32'd1);
        tick();
        apply("load_use_m", r_ins(5'd8, 5'd8, 5'd9, F_ADDU), NOP, 5'd0, i_ins(O_LW, 5'd0, 5'd8), 5'd8);
        check("lu_m_stall", {31'd0, stall}, 32'd0);
        check("lu_cnt1", stall_cnt, 32'd1);
        tick();
        apply("beq_vs_m_lw", i_ins(O_BEQ, 5'd8, 5'd0), NOP, 5'd0, i_ins(O_LW, 5'd0, 5'd8), 5'd8);
        check("beq_m_lw_stall", {31'd0, stall}, 32'd1);
        tick();

        // Branch hazard against an ALU result.
        apply("beq_vs_e_addu", i_ins(O_BEQ, 5'd5, 5'd0), r_ins(5'd1, 5'd2, 5'd5, F_ADDU), 5'd5, NOP, 5'd0);
        check("beq_e_stall", {31'd0, stall}, 32'd1);
        tick();
        apply("beq_vs_m_addu", i_ins(O_BEQ, 5'd5, 5'd0), NOP, 5'd0, r_ins(5'd1, 5'd2, 5'd5, F_ADDU), 5'd5);
        check("beq_m_stall", {31'd0, stall}, 32'd0);
        tick();
        apply("sw_rt_vs_addu", i_ins(O_SW, 5'd6, 5'd5), r_ins(5'd1, 5'd2, 5'd5, F_ADDU), 5'd5, NOP, 5'd0);
        check("sw_rt_addu", {31'd0, stall}, 32'd0);
        tick();
        apply("sw_rt_vs_lw", i_ins(O_SW, 5'd6, 5'd5), i_ins(O_LW, 5'd0, 5'd5), 5'd5, NOP, 5'd0);
        check("sw_rt_lw", {31'd0, stall}, 32'd0);
        tick();
        apply("sw_rs_vs_lw", i_ins(O_SW, 5'd5, 5'd6), i_ins(O_LW, 5'd0, 5'd5), 5'd5, NOP, 5'd0);
        check("sw_rs_lw", {31'd0, stall}, 32'd1);
        tick();

        // Register 0 never stalls.
        apply("zero_e", r_ins(5'd0, 5'd0, 5'd1, F_ADDU), i_ins(O_LW, 5'd0, 5'd0), 5'd0, NOP, 5'd0);
        check("zero_e_stall", {31'd0, stall}, 32'd0);
        tick();
        apply("zero_m", i_ins(O_BEQ, 5'd0, 5'd0), NOP, 5'd0, i_ins(O_LW, 5'd0, 5'd0), 5'd0);
        check("zero_m_stall", {31'd0, stall}, 32'd0);
        tick();
        apply("mflo_idle", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), NOP, 5'd0, NOP, 5'd0);
        check("mflo_idle_stall", {31'd0, stall}, 32'd0);
        check("cnt_before_md", stall_cnt, 32'd4);
        tick();

        // Mult: one start cycle, 5 busy cycles, mflo held throughout.
        apply("mult_start", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), r_ins(5'd1, 5'd2, 5'd0, F_MULT), 5'd0, NOP, 5'd0);
        check("mult_start", {31'd0, md_start}, 32'd1);
        check("mult_start_busy", {31'd0, md_busy}, 32'd0);
        check("mult_start_stall", {31'd0, stall}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply("mult_busy", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), NOP, 5'd0, NOP, 5'd0);
            check("mult_busy", {31'd0, md_busy}, 32'd1);
            check("mult_no_start", {31'd0, md_start}, 32'd0);
            check("mult_busy_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        apply("mult_done", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), NOP, 5'd0, NOP, 5'd0);
        check("mult_done_busy", {31'd0, md_busy}, 32'd0);
        check("mult_done_stall", {31'd0, stall}, 32'd0);
        tick();

        // Div: 10 busy cycles.
        apply("div_start", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), r_ins(5'd1, 5'd2, 5'd0, F_DIV), 5'd0, NOP, 5'd0);
        check("div_start", {31'd0, md_start}, 32'd1);
        check("div_start_stall", {31'd0, stall}, 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            apply("div_busy", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), NOP, 5'd0, NOP, 5'd0);
            check("div_busy", {31'd0, md_busy}, 32'd1);
            check("div_busy_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        apply("div_done", r_ins(5'd0, 5'd0, 5'd3, F_MFLO), NOP, 5'd0, NOP, 5'd0);
        check("div_done_busy", {31'd0, md_busy}, 32'd0);
        check("div_done_stall", {31'd0, stall}, 32'd0);
        check("cnt_after_md", stall_cnt, 32'd21);
        tick();

        // Reset three cycles into a div countdown.
        apply("div2_start", NOP, r_ins(5'd1, 5'd2, 5'd0, F_DIV), 5'd0, NOP, 5'd0);
        check("div2_start", {31'd0, md_start}, 32'd1);
        tick();
        apply("div2_busy1", NOP, NOP, 5'd0, NOP, 5'd0);
        tick();
        apply("div2_busy2", NOP, NOP, 5'd0, NOP, 5'd0);
        tick();
        reset = 1'b1;
        apply("div2_busy3_rst", NOP, NOP, 5'd0, NOP, 5'd0);
        check("div2_busy3", {31'd0, md_busy}, 32'd1);
        tick();
        reset = 1'b0;
        apply("after_rst", NOP, NOP, 5'd0, NOP, 5'd0);
        check("ar_busy", {31'd0, md_busy}, 32'd0);
        check("ar_cnt", stall_cnt, 32'd0);
        check("ar_start", {31'd0, md_start}, 32'd0);
        tick();
        apply("after_rst2", NOP, NOP, 5'd0, NOP, 5'd0);
        check("ar2_busy", {31'd0, md_busy}, 32'd0);
        check("ar2_start", {31'd0, md_start}, 32'd0);
        tick();

        // Seven forced stall cycles.
        for (int i = 0; i < 7; i++) begin
            apply("stall7", r_ins(5'd8, 5'd8, 5'd9, F_ADDU), i_ins(O_LW, 5'd0, 5'd8), 5'd8, NOP, 5'd0);
            tick();
        end
        apply("stall7_done", NOP, NOP, 5'd0, NOP, 5'd0);
        check("cnt_seven", stall_cnt, 32'd7);
        tick();

        // Saturation: preload the counter just below all-ones.
        force dut.stall_cnt_reg = 32'hFFFF_FFFD;
        apply("sat_preload", r_ins(5'd8, 5'd8, 5'd9, F_ADDU), i_ins(O_LW, 5'd0, 5'd8), 5'd8, NOP, 5'd0);
        check("sat_preload", stall_cnt, 32'hFFFF_FFFD);
        release dut.stall_cnt_reg;
        tick();
        check("sat_fe", stall_cnt, 32'hFFFF_FFFE);
        tick();
        check("sat_ff", stall_cnt, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        end
        apply("sat_end", NOP, NOP, 5'd0, NOP, 5'd0);
        check("sat_end_stall", {31'd0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
